rom_writer: RTL and testbench

ROM_WRITER -- requirements
Module: rom_writer

---
 rtl/rom_pkg.sv | 53 +++++
 rtl/rom_phase_timer.sv | 29 ++
 rtl/rom_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_rom_writer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the bipolar PROM programmer: chip IDs, widths, mode pin codes, status codes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rom_pkg;

    localparam int CHIP_IP3604 = 1;
    localparam int CHIP_IP3601 = 2;

    localparam int IP3604_DATA_WIDTH    = 8;
    localparam int IP3604_ADDRESS_WIDTH = 9;
    localparam int IP3601_DATA_WIDTH    = 4;
    localparam int IP3601_ADDRESS_WIDTH = 8;

    // V1..V4 mode pin patterns, bit0 = V1.
    localparam logic [3:0] OP_READ_IP3604    = 4'b0011;
    localparam logic [3:0] OP_PROGRAM_IP3604 = 4'b1100;
    localparam logic [3:0] OP_READ_IP3601    = 4'b0000;
    localparam logic [3:0] OP_PROGRAM_IP3601 = 4'b1111;

    typedef enum logic [1:0] {
        STATUS_OK              = 2'd0,
        STATUS_RETRY_EXHAUSTED = 2'd1,
        STATUS_ILLEGAL_BIT     = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_SETTLE,
        ST_CHECK,
        ST_SETUP,
        ST_PULSE,
        ST_RECOVER,
        ST_VERIFY,
        ST_RESPOND
    } state_e;

    function automatic logic [3:0] read_code(input int chip);
        return (chip == CHIP_IP3601) ? OP_READ_IP3601 : OP_READ_IP3604;
    endfunction

    function automatic logic [3:0] program_code(input int chip);
        return (chip == CHIP_IP3601) ? OP_PROGRAM_IP3601 : OP_PROGRAM_IP3604;
    endfunction

    function automatic int data_width_of(input int chip);
        return (chip == CHIP_IP3601) ? IP3601_DATA_WIDTH : IP3604_DATA_WIDTH;
    endfunction

    function automatic int address_width_of(input int chip);
        return (chip == CHIP_IP3601) ? IP3601_ADDRESS_WIDTH : IP3604_ADDRESS_WIDTH;
    endfunction

endpackage

// File: rtl/rom_phase_timer.sv
// Down-counter that times one programming phase: load a length N, done is high on the Nth cycle after load.
// Latency: done asserts exactly N cycles after the load cycle; stays high until the next load.
// Backpressure: none; the caller reloads on every phase entry.
module rom_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_len,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load N-1 so the final phase cycle is the one where the count reads zero; hold at zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_len - CNT_W'(1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/rom_writer.sv
// Programs one PROM word per command: read, blow needed fuses LSB-first with pulse/verify/retry, report status.
// Latency: SETTLE+2 cycles with nothing to blow; each pulse attempt adds SETUP+PULSE+RECOVER+SETTLE+1 cycles.
// Backpressure: cmd_ready is high only in IDLE; commands offered while busy are not captured.
module rom_writer
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH     = IP3604_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = IP3604_ADDRESS_WIDTH,
    parameter int CHIP           = CHIP_IP3604,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SETUP_CYCLES   = 8,
    parameter int PULSE_CYCLES   = 100,
    parameter int RECOVER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [3:0]               operation,
    output logic [DATA_WIDTH-1:0]    prog_bit,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_status,
    output logic [DATA_WIDTH-1:0]    rsp_data
);

    localparam int MAX_AB    = (SETTLE_CYCLES > SETUP_CYCLES) ? SETTLE_CYCLES : SETUP_CYCLES;
    localparam int MAX_CD    = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
    localparam int MAX_PHASE = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);
    localparam int IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int RTY_W     = $clog2(MAX_RETRIES + 1);

    state_e                   state;
    state_e                   state_nxt;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    sample_q;
    logic [IDX_W-1:0]         idx_q;
    logic [RTY_W-1:0]         retry_q;
    status_e                  status_q;

    logic                     timer_load;
    logic [CNT_W-1:0]         timer_len;
    logic                     timer_done;

    logic                     capture;
    logic                     take_sample;
    logic                     idx_load;
    logic                     retry_clr;
    logic                     retry_inc;
    logic                     status_set;
    status_e                  status_nxt;

    logic [DATA_WIDTH-1:0]    need;
    logic                     illegal;
    logic                     found;
    logic [IDX_W-1:0]         found_idx;

    rom_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_len (timer_len),
        .done     (timer_done)
    );

    // A blown fuse reads 1 and cannot be cleared; a bit still needed is wanted-1 but read-0.
    assign need    = data_q & ~sample_q;
    assign illegal = |(sample_q & ~data_q);

    // Lowest needed bit at or above the current index; bits below were already handled.
    always_comb begin
        found     = 1'b0;
        found_idx = idx_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (!found && need[i] && (IDX_W'(i) >= idx_q)) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, phase timer loads, datapath strobes and pin outputs.
    always_comb begin
        state_nxt   = state;
        timer_load  = 1'b0;
        timer_len   = '0;
        capture     = 1'b0;
        take_sample = 1'b0;
        idx_load    = 1'b0;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        status_set  = 1'b0;
        status_nxt  = STATUS_OK;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        prog_bit    = '0;
        operation   = read_code(CHIP);

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    capture    = 1'b1;
                    timer_load = 1'b1;
                    timer_len  = CNT_W'(SETTLE_CYCLES);
                    state_nxt  = ST_READ_SETTLE;
                end
            end
            ST_READ_SETTLE, ST_VERIFY: begin
                if (timer_done) begin
                    take_sample = 1'b1;
                    state_nxt   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (illegal) begin
                    status_set = 1'b1;
                    status_nxt = STATUS_ILLEGAL_BIT;
                    state_nxt  = ST_RESPOND;
                end else if (!found) begin
                    status_set = 1'b1;
                    status_nxt = STATUS_OK;
                    state_nxt  = ST_RESPOND;
                end else if ((found_idx == idx_q) && (retry_q == RTY_W'(MAX_RETRIES))) begin
                    status_set = 1'b1;
                    status_nxt = STATUS_RETRY_EXHAUSTED;
                    state_nxt  = ST_RESPOND;
                end else begin
                    idx_load   = 1'b1;
                    retry_clr  = (found_idx != idx_q);
                    timer_load = 1'b1;
                    timer_len  = CNT_W'(SETUP_CYCLES);
                    state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                operation = program_code(CHIP);
                if (timer_done) begin
                    retry_inc  = 1'b1;
                    timer_load = 1'b1;
                    timer_len  = CNT_W'(PULSE_CYCLES);
                    state_nxt  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                operation = program_code(CHIP);
                prog_bit  = DATA_WIDTH'(1) << idx_q;
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_len  = CNT_W'(RECOVER_CYCLES);
                    state_nxt  = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                operation = program_code(CHIP);
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_len  = CNT_W'(SETTLE_CYCLES);
                    state_nxt  = ST_VERIFY;
                end
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command capture, readback sampling, bit/retry bookkeeping and response status.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            sample_q <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            status_q <= STATUS_OK;
        end else begin
            if (capture) begin
                addr_q  <= cmd_address;
                data_q  <= cmd_data;
                idx_q   <= '0;
                retry_q <= '0;
            end
            if (take_sample) begin
                sample_q <= data_line_in;
            end
            if (idx_load) begin
                idx_q <= found_idx;
            end
            if (retry_clr) begin
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + RTY_W'(1);
            end
            if (status_set) begin
                status_q <= status_nxt;
            end
        end
    end

    assign address_line = addr_q;
    assign rsp_status   = status_q;
    assign rsp_data     = sample_q;

endmodule

// File: tb/tb_rom_writer.sv
// Bench for rom_writer: fuse-level PROM models, a per-cycle protocol monitor and directed commands.
// Latency: n/a.
// Backpressure: commands are issued only once cmd_ready is seen high.
`timescale 1ns/1ps
module tb_rom_writer;

    localparam int DW      = 8;
    localparam int AW      = 9;
    localparam int SETTLE  = 4;
    localparam int SETUP   = 8;
    localparam int PULSE   = 100;
    localparam int RECOVER = 8;
    localparam int MAXR    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] data_line_in;
    logic [AW-1:0] address_line;
    logic [3:0]    operation;
    logic [DW-1:0] prog_bit;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [DW-1:0] rsp_data;

    logic          cmd_valid_b;
    logic          cmd_ready_b;
    logic [7:0]    cmd_address_b;
    logic [3:0]    cmd_data_b;
    logic [3:0]    data_line_in_b;
    logic [7:0]    address_line_b;
    logic [3:0]    operation_b;
    logic [3:0]    prog_bit_b;
    logic          rsp_valid_b;
    logic [1:0]    rsp_status_b;
    logic [3:0]    rsp_data_b;

    // PROM models: fuse state per word, plus a mask of fuses that never blow.
    logic [DW-1:0] prom  [0:(1<<AW)-1];
    logic [DW-1:0] stuck [0:(1<<AW)-1];
    logic [3:0]    prom_b [0:255];

    assign data_line_in   = prom[address_line];
    assign data_line_in_b = prom_b[address_line_b];

    rom_writer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CHIP(1),
        .SETTLE_CYCLES(SETTLE), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
        .RECOVER_CYCLES(RECOVER), .MAX_RETRIES(MAXR)
    ) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .data_line_in(data_line_in),
        .address_line(address_line), .operation(operation), .prog_bit(prog_bit),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data)
    );

    rom_writer #(
        .DATA_WIDTH(4), .ADDRESS_WIDTH(8), .CHIP(2),
        .SETTLE_CYCLES(SETTLE), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
        .RECOVER_CYCLES(RECOVER), .MAX_RETRIES(MAXR)
    ) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_address(cmd_address_b), .cmd_data(cmd_data_b), .data_line_in(data_line_in_b),
        .address_line(address_line_b), .operation(operation_b), .prog_bit(prog_bit_b),
        .rsp_valid(rsp_valid_b), .rsp_status(rsp_status_b), .rsp_data(rsp_data_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outcome of the running command; pulse sequences packed as (bit+1) per nibble.
    logic [AW-1:0] exp_addr = '0;
    logic [1:0]    exp_status;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_sig;
    int            exp_n;

    logic [31:0]   got_sig = '0;
    int            got_n = 0;
    int            rsp_count = 0;
    logic [1:0]    last_status;
    logic [DW-1:0] last_data;

    // Outcome from the fuse rules alone: refuse if a fuse must be unblown, else blow needed bits upward.
    task automatic model(input logic [DW-1:0] w0, input logic [DW-1:0] stk, input logic [DW-1:0] d);
        logic [DW-1:0] w;
        w       = w0;
        exp_sig = '0;
        exp_n   = 0;
        if ((w & ~d) != '0) begin
            exp_status = 2'd2;
            exp_data   = w;
            return;
        end
        for (int i = 0; i < DW; i++) begin
            if (d[i] && !w[i]) begin
                if (stk[i]) begin
                    for (int r = 0; r < MAXR; r++) begin
                        exp_sig = exp_sig | (32'(i + 1) << (4 * exp_n));
                        exp_n++;
                    end
                    exp_status = 2'd1;
                    exp_data   = w;
                    return;
                end
                exp_sig = exp_sig | (32'(i + 1) << (4 * exp_n));
                exp_n++;
                w[i] = 1'b1;
            end
        end
        exp_status = 2'd0;
        exp_data   = w;
    endtask

    int            prog_run = 0;
    int            pulse_len = 0;
    int            post_len = 0;
    bit            post_pending = 0;
    bit            rsp_prev = 0;
    logic [DW-1:0] pulse_mask = '0;

    // Per-cycle check of the IP3604 instance: pin codes, pulse framing, address hold, responses.
    always @(negedge clk) begin
        if (reset) begin
            prog_run     = 0;
            pulse_len    = 0;
            post_pending = 0;
            rsp_prev     = 0;
        end else begin
            chk("op_code_legal", 32'(operation == 4'b0011 || operation == 4'b1100), 32'd1);
            if (prog_bit != '0) begin
                chk("prog_onehot", 32'($onehot(prog_bit)), 32'd1);
                chk("prog_op", 32'(operation), 32'hC);
                if (pulse_len == 0) begin
                    chk("setup_len", 32'(prog_run >= SETUP), 32'd1);
                    pulse_mask = prog_bit;
                    for (int i = 0; i < DW; i++) begin
                        if (prog_bit[i] && got_n < 8) begin
                            got_sig = got_sig | (32'(i + 1) << (4 * got_n));
                            got_n++;
                        end
                    end
                end
                chk("prog_stable", 32'(prog_bit), 32'(pulse_mask));
                pulse_len++;
            end else if (pulse_len != 0) begin
                chk("pulse_len", 32'(pulse_len), 32'(PULSE));
                prom[address_line] = prom[address_line] | (pulse_mask & ~stuck[address_line]);
                pulse_len    = 0;
                post_pending = 1;
                post_len     = 0;
            end
            if (post_pending) begin
                if (operation == 4'b1100) begin
                    post_len++;
                end else begin
                    chk("recover_len", 32'(post_len >= RECOVER), 32'd1);
                    post_pending = 0;
                end
            end
            prog_run = (operation == 4'b1100) ? prog_run + 1 : 0;
            if (!cmd_ready) begin
                chk("addr_hold", 32'(address_line), 32'(exp_addr));
            end
            if (rsp_valid) begin
                chk("rsp_single", 32'(rsp_prev), 32'd0);
                chk("rsp_op_read", 32'(operation), 32'h3);
                chk("rsp_status", 32'(rsp_status), 32'(exp_status));
                chk("rsp_data", 32'(rsp_data), 32'(exp_data));
                chk("pulse_seq", got_sig, exp_sig);
                chk("pulse_count", 32'(got_n), 32'(exp_n));
                last_status = rsp_status;
                last_data   = rsp_data;
                rsp_count++;
            end
            rsp_prev = rsp_valid;
        end
    end

    int         prog_cyc_b = 0;
    int         pulse_cyc_b = 0;
    int         rsp_count_b = 0;
    logic [1:0] last_status_b;
    logic [3:0] last_data_b;

    // Per-cycle check of the IP3601 instance; its fuses blow as soon as they are driven.
    always @(negedge clk) begin
        if (!reset) begin
            chk("op_b_legal", 32'(operation_b == 4'b0000 || operation_b == 4'b1111), 32'd1);
            if (operation_b == 4'b1111) prog_cyc_b++;
            if (prog_bit_b != '0) begin
                pulse_cyc_b++;
                chk("op_b_pulse", 32'(operation_b), 32'hF);
                prom_b[address_line_b] = prom_b[address_line_b] | prog_bit_b;
            end
            if (rsp_valid_b) begin
                chk("op_b_rsp_read", 32'(operation_b), 32'h0);
                last_status_b = rsp_status_b;
                last_data_b   = rsp_data_b;
                rsp_count_b++;
            end
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        chk("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit junk);
        int start;
        bit done;
        wait_ready();
        model(prom[a], stuck[a], d);
        exp_addr = a;
        got_sig  = '0;
        got_n    = 0;
        start    = rsp_count;
        cmd_valid   = 1'b1;
        cmd_address = a;
        cmd_data    = d;
        @(negedge clk);
        if (junk) begin
            cmd_address = a + AW'(1);
            cmd_data    = 8'hFF;
            repeat (50) @(negedge clk);
        end
        cmd_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (rsp_count != start) done = 1;
        end
        chk("rsp_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int  start;
        bit  done;
        reset = 1'b1;
        cmd_valid = 1'b0;   cmd_address = '0;   cmd_data = '0;
        cmd_valid_b = 1'b0; cmd_address_b = '0; cmd_data_b = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            prom[i]  = '0;
            stuck[i] = '0;
        end
        for (int i = 0; i < 256; i++) prom_b[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_prog_bit", 32'(prog_bit), 32'd0);
        chk("rst_operation", 32'(operation), 32'h3);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_address", 32'(address_line), 32'd0);
        chk("rst_operation_b", 32'(operation_b), 32'h0);
        reset = 1'b0;

        // Blank word, all fuses take first time.
        run_cmd(9'd5, 8'hA5, 0);
        chk("a5_status", 32'(last_status), 32'd0);
        chk("a5_data", 32'(last_data), 32'hA5);
        chk("a5_pulses", got_sig, 32'h8631);
        chk("a5_prom", 32'(prom[5]), 32'hA5);

        // Bit 3 never blows: three attempts, then give up.
        stuck[6] = 8'h08;
        run_cmd(9'd6, 8'h08, 0);
        chk("stuck_status", 32'(last_status), 32'd1);
        chk("stuck_data", 32'(last_data), 32'h00);
        chk("stuck_pulses", got_sig, 32'h444);

        // Word already has a fuse the target wants unblown.
        prom[7] = 8'h01;
        run_cmd(9'd7, 8'h02, 0);
        chk("illegal_status", 32'(last_status), 32'd2);
        chk("illegal_data", 32'(last_data), 32'h01);
        chk("illegal_pulses", 32'(got_n), 32'd0);

        // Nothing to blow.
        run_cmd(9'd12, 8'h00, 0);
        chk("zero_status", 32'(last_status), 32'd0);
        chk("zero_pulses", 32'(got_n), 32'd0);

        // Second request held up while busy must not be taken.
        run_cmd(9'd10, 8'h81, 1);
        chk("busy_status", 32'(last_status), 32'd0);
        chk("busy_data", 32'(last_data), 32'h81);
        chk("busy_pulses", got_sig, 32'h81);
        chk("busy_no_capture", 32'(prom[11]), 32'h00);

        // Reset in the middle of the second pulse drops the command.
        wait_ready();
        exp_addr = 9'd9;
        got_sig  = '0;
        got_n    = 0;
        start    = rsp_count;
        cmd_valid = 1'b1; cmd_address = 9'd9; cmd_data = 8'h30;
        @(negedge clk);
        cmd_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (got_n >= 2) done = 1;
        end
        chk("second_pulse_seen", 32'(got_n), 32'd2);
        repeat (10) @(negedge clk);
        chk("prog_before_reset", 32'(prog_bit), 32'h20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("prog_after_reset", 32'(prog_bit), 32'd0);
        chk("addr_after_reset", 32'(address_line), 32'd0);
        chk("rsp_after_reset", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        repeat (300) @(negedge clk);
        chk("no_rsp_after_reset", 32'(rsp_count), 32'(start));
        chk("partial_prom", 32'(prom[9]), 32'h10);

        // IP3601: 4-bit word, inverted mode codes.
        prog_cyc_b  = 0;
        pulse_cyc_b = 0;
        start = rsp_count_b;
        cmd_valid_b = 1'b1; cmd_address_b = 8'd3; cmd_data_b = 4'h3;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rsp_count_b != start) done = 1;
        end
        chk("b_rsp_timeout", 32'(done), 32'd1);
        chk("b_status", 32'(last_status_b), 32'd0);
        chk("b_data", 32'(last_data_b), 32'h3);
        chk("b_prog_cycles", 32'(prog_cyc_b), 32'(2 * (SETUP + PULSE + RECOVER)));
        chk("b_pulse_cycles", 32'(pulse_cyc_b), 32'(2 * PULSE));
        chk("b_idle_read", 32'(operation_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
